// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: CRC16 constants and the
// serializer state encoding.
package usb_tx_pkg;

  localparam logic [15:0] USB_CRC16_POLY     = 16'h8005;
  localparam logic [15:0] USB_CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] USB_CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } tx_crc_state_t;

endpackage

// File: rtl/crc_16bit_gen_if.sv
// Byte-wide valid/ready payload channel from the packet builder into the
// CRC16 generator/serializer.
interface crc_16bit_gen_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/crc16_lfsr.sv
// Serial CRC16 register, MSB-first form. Either folds one data bit into the
// remainder or shifts the remainder out without feedback.
module crc16_lfsr
  import usb_tx_pkg::*;
#(
  parameter logic [15:0] POLY = USB_CRC16_POLY,
  parameter logic [15:0] INIT = USB_CRC16_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        update,
  input  logic        shift_only,
  input  logic        din,
  output logic [15:0] crc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= INIT;
    end else if (update) begin
      crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? POLY : 16'h0000);
    end else if (shift_only) begin
      crc <= {crc[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc_16bit_gen.sv
// USB CRC16 transmit generator: serializes payload bytes LSB-first on each
// shift_en strobe, then appends the complemented CRC16 high bit first.
module crc_16bit_gen
  import usb_tx_pkg::*;
#(
  parameter logic [15:0] POLY = USB_CRC16_POLY,
  parameter logic [15:0] INIT = USB_CRC16_INIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           shift_en,
  input  logic           zlp,
  crc_16bit_gen_if.slave bus,
  output logic           serial_out,
  output logic           bit_valid,
  output logic           busy,
  output logic           done,
  output logic           underrun
);

  tx_crc_state_t state;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          hold_last;
  logic [7:0]    sh;
  logic          sh_last;
  logic [2:0]    cnt;
  logic [3:0]    crc_cnt;
  logic [15:0]   crc;
  logic          ready;

  logic accept, byte_end, crc_end, start_zlp, dropped;
  logic lfsr_init, lfsr_update, lfsr_shift;

  assign accept    = bus.in_valid && ready;
  assign byte_end  = (state == DATA) && shift_en && (cnt == 3'd7);
  assign crc_end   = (state == CRC) && shift_en && (crc_cnt == 4'hF);
  assign start_zlp = (state == IDLE) && zlp && !accept;
  assign dropped   = byte_end && !hold_full && !accept && !sh_last;

  assign lfsr_init   = clear || start_zlp || dropped || crc_end;
  assign lfsr_update = !clear && (state == DATA) && shift_en;
  assign lfsr_shift  = !clear && (state == CRC) && shift_en;

  crc16_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .init       (lfsr_init),
    .update     (lfsr_update),
    .shift_only (lfsr_shift),
    .din        (sh[0]),
    .crc        (crc)
  );

  // Once the final byte sits in the shifter, nothing more is taken until IDLE.
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    ready      = 1'b0;
    serial_out = 1'b0;
    bit_valid  = 1'b0;
    unique case (state)
      IDLE: ready = 1'b1;
      DATA: begin
        ready      = !hold_full && !sh_last;
        serial_out = sh[0];
        bit_valid  = 1'b1;
      end
      CRC: begin
        serial_out = ~crc[15];
        bit_valid  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready = ready;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    done     <= 1'b0;
    underrun <= 1'b0;
    if (rst || clear) begin
      state     <= IDLE;
      hold_data <= 8'h00;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      sh        <= 8'h00;
      sh_last   <= 1'b0;
      cnt       <= 3'd0;
      crc_cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sh      <= bus.in_data;
            sh_last <= bus.in_last;
            cnt     <= 3'd0;
            state   <= DATA;
          end else if (zlp) begin
            crc_cnt <= 4'd0;
            state   <= CRC;
          end
        end
        DATA: begin
          if (byte_end) begin
            cnt <= 3'd0;
            if (hold_full) begin
              sh        <= hold_data;
              sh_last   <= hold_last;
              hold_full <= 1'b0;
            end else if (accept) begin
              // A byte arriving exactly at the boundary goes straight in.
              sh      <= bus.in_data;
              sh_last <= bus.in_last;
            end else if (sh_last) begin
              crc_cnt <= 4'd0;
              state   <= CRC;
            end else begin
              underrun <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            if (shift_en) begin
              sh  <= sh >> 1;
              cnt <= cnt + 3'd1;
            end
            if (accept) begin
              hold_data <= bus.in_data;
              hold_last <= bus.in_last;
              hold_full <= 1'b1;
            end
          end
        end
        CRC: begin
          if (shift_en) begin
            crc_cnt <= crc_cnt + 4'd1;
            if (crc_cnt == 4'hF) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_16bit_gen.sv
// Randomized self-checking bench for crc_16bit_gen against a byte-wise
// reflected CRC-16/USB model and a serial receive-side residual checker.
module tb_crc_16bit_gen;
  import usb_tx_pkg::*;

  logic clk = 1'b0;
  logic rst, clear, shift_en, zlp;
  logic serial_out, bit_valid, busy, done, underrun;

  crc_16bit_gen_if bus ();

  crc_16bit_gen dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .shift_en   (shift_en),
    .zlp        (zlp),
    .bus        (bus),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] pkt[$];
  bit         got[$];
  int         done_cnt, und_cnt, bv_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CRC-16/USB computed byte-wise in reflected form (poly 0xA001, xorout 0xFFFF).
  function automatic logic [15:0] usb_crc16(input logic [7:0] d[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (d[i]) begin
      c = c ^ {8'h00, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  // Receive-side checker: a valid packet leaves the residual constant.
  function automatic logic [15:0] rx_residual(input bit b[$]);
    logic [15:0] c = USB_CRC16_INIT;
    foreach (b[i]) begin
      if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ USB_CRC16_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic drive_idle();
    clear = 0; shift_en = 0; zlp = 0;
    bus.in_valid = 0; bus.in_last = 0; bus.in_data = 8'h00;
  endtask

  // Runs one packet of pkt[]; stops on done, underrun or clear.
  task automatic run(input int period, input bit use_last, input bit use_zlp,
                     input int clear_at);
    int idx = 0;
    int cyc = 0;
    bit fin = 0;
    got.delete();
    done_cnt = 0; und_cnt = 0; bv_cnt = 0;
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      zlp = use_zlp && (cyc == 0);
      if (idx < pkt.size()) begin
        bus.in_valid = 1;
        bus.in_data  = pkt[idx];
        bus.in_last  = use_last && (idx == pkt.size() - 1);
      end else begin
        bus.in_valid = 0;
        bus.in_last  = 0;
      end
      shift_en = ((cyc % period) == period - 1);
      clear    = (clear_at >= 0) && (got.size() == clear_at);
      if (clear) shift_en = 1;
      @(negedge clk);
      if (bit_valid) bv_cnt++;
      if (shift_en && bit_valid) got.push_back(serial_out);
      if (bus.in_valid && bus.in_ready) idx++;
      if (done) done_cnt++;
      if (underrun) und_cnt++;
      if (done || underrun || clear) fin = 1;
      cyc++;
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive_idle();
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (underrun) und_cnt++;
    end
  endtask

  task automatic check_packet(input string tag);
    bit          exp[$];
    logic [15:0] c;
    foreach (pkt[i]) for (int k = 0; k < 8; k++) exp.push_back(pkt[i][k]);
    c = usb_crc16(pkt);
    for (int k = 0; k < 16; k++) exp.push_back(c[k]);
    check({tag, "_nbits"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), {31'd0, got[i]}, {31'd0, exp[i]});
    check({tag, "_residual"}, {16'd0, rx_residual(got)}, {16'd0, USB_CRC16_RESIDUAL});
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_underrun"}, und_cnt, 0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_bit_valid", {31'd0, bit_valid}, 0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("rst_serial_out", {31'd0, serial_out}, 0);
    check("rst_pulses", {30'd0, done, underrun}, 0);
    check("rst_crc", {16'd0, dut.crc}, {16'd0, USB_CRC16_INIT});

    // Reset mid-DATA after three strobes.
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_data = 8'h5A; bus.in_last = 1;
    @(posedge clk); #1;
    drive_idle();
    repeat (3) begin shift_en = 1; @(posedge clk); #1; end
    shift_en = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_bit_valid", {31'd0, bit_valid}, 0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
    check("midrst_crc", {16'd0, dut.crc}, {16'd0, USB_CRC16_INIT});

    // ZLP: sixteen zero bits.
    pkt.delete();
    run(2, 1, 1, -1);
    check_packet("zlp");

    // "123456789" with shift_en every fourth cycle.
    pkt.delete();
    for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
    run(4, 1, 0, -1);
    check_packet("check_vec");

    // Back-to-back throughput.
    pkt = '{8'h00, 8'hFF, 8'hA5};
    run(1, 1, 0, -1);
    check_packet("b2b");
    check("b2b_bit_valid_cycles", bv_cnt, 40);

    // Underrun: one byte without last, then nothing offered.
    pkt = '{8'h12};
    run(1, 0, 0, -1);
    check("und_pulses", und_cnt, 1);
    check("und_done", done_cnt, 0);
    check("und_nbits", got.size(), 8);
    check("und_busy", {31'd0, busy}, 0);

    // Clear after five CRC bits, then a fresh single-byte packet.
    pkt = '{8'h00};
    run(2, 1, 0, 13);
    check("clr_done", done_cnt, 0);
    check("clr_underrun", und_cnt, 0);
    check("clr_busy", {31'd0, busy}, 0);
    check("clr_crc", {16'd0, dut.crc}, {16'd0, USB_CRC16_INIT});
    run(3, 1, 0, -1);
    check_packet("after_clr");

    // Randomized packets.
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(1, 6);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      run($urandom_range(1, 3), 1, 0, -1);
      check_packet($sformatf("rnd%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
